// File: rtl/ex_stage_muldiv.sv
// rtl/ex_stage_muldiv.sv - execute stage with single-cycle ALU/branch and iterative RV32M engine
module ex_stage_muldiv #(
    parameter int XLEN     = 32,
    parameter int MD_ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mem_read_en,
    input  logic            mem_write_en,
    input  logic            mem_to_reg_en,
    input  logic            jumpl_en,
    input  logic            branch_en,
    input  logic [XLEN-1:0] A_in,
    input  logic [XLEN-1:0] B_in,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] PC_n,
    input  logic [XLEN-1:0] PC_in,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] rs2data_out,
    output logic            mem_read_n,
    output logic            mem_write_n,
    output logic            mem_to_reg_n,
    output logic            jumpl_n,
    output logic            branch_taken,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [4:0]        cnt;

    // Mul/div engine: lo holds multiplier/dividend, hi accumulates product/remainder.
    logic [XLEN-1:0]   md_hi, md_lo, md_op, md_a;
    logic [2:0]        md_f3;
    logic              md_neg_q, md_neg_r, md_bzero;

    // Side-band captured at M-op accept, released with the result.
    logic [XLEN-1:0]   h_rs2, h_pc;
    logic [31:0]       h_instr;
    logic              h_mr, h_mw, h_mtr, h_jl, h_bt;

    logic              is_mop, accept;
    logic [2:0]        f3;
    logic [XLEN-1:0]   alu_val;
    logic              br_cond;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_rs, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, md_res;

    assign f3       = instr[14:12];
    assign is_mop   = (instr[6:0] == 7'b0110011) && (instr[31:25] == 7'b0000001);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle ALU; a jump link overrides the operation with PC+4.
    always_comb begin
        alu_val = B_in;
        case (alu_sel)
            4'd0:    alu_val = A_in + B_in;
            4'd1:    alu_val = A_in - B_in;
            4'd2:    alu_val = A_in & B_in;
            4'd3:    alu_val = A_in | B_in;
            4'd4:    alu_val = A_in ^ B_in;
            4'd5:    alu_val = A_in << B_in[4:0];
            4'd6:    alu_val = A_in >> B_in[4:0];
            4'd7:    alu_val = $signed(A_in) >>> B_in[4:0];
            4'd8:    alu_val = {{(XLEN-1){1'b0}}, ($signed(A_in) < $signed(B_in))};
            4'd9:    alu_val = {{(XLEN-1){1'b0}}, (A_in < B_in)};
            default: alu_val = B_in;
        endcase
        if (jumpl_en) alu_val = PC_n;
    end

    // Branch condition from funct3, comparing rs1 against rs2 data.
    always_comb begin
        br_cond = 1'b0;
        case (f3)
            3'b000:  br_cond = (A_in == rs2_data);
            3'b001:  br_cond = (A_in != rs2_data);
            3'b100:  br_cond = ($signed(A_in) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(A_in) >= $signed(rs2_data));
            3'b110:  br_cond = (A_in <  rs2_data);
            3'b111:  br_cond = (A_in >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    // Operand signedness by funct3; the engine always works on magnitudes.
    always_comb begin
        a_sgn = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        b_sgn = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        a_neg = a_sgn && A_in[XLEN-1];
        b_neg = b_sgn && B_in[XLEN-1];
        a_mag = a_neg ? -A_in : A_in;
        b_mag = b_neg ? -B_in : B_in;
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_op} : '0);
        div_rs   = {md_hi, md_lo[XLEN-1]};
        div_ge   = (div_rs >= {1'b0, md_op});
        div_diff = div_rs - {1'b0, md_op};
    end

    // Sign fixup and result selection, consumed in DONE.
    always_comb begin
        prod   = {md_hi, md_lo};
        prod_s = md_neg_q ? -prod : prod;
        quo    = md_neg_q ? -md_lo : md_lo;
        rem    = md_neg_r ? -md_hi : md_hi;
        case (md_f3)
            3'b000:          md_res = prod_s[XLEN-1:0];
            3'b100, 3'b101:  md_res = md_bzero ? {XLEN{1'b1}} : quo;
            3'b110, 3'b111:  md_res = md_bzero ? md_a : rem;
            default:         md_res = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // Control FSM: IDLE -> BUSY (MD_ITERS steps) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                S_IDLE: if (accept && is_mop) begin
                    state <= S_BUSY;
                    cnt   <= 5'd0;
                end
                S_BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(MD_ITERS - 1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Engine datapath: load magnitudes and side-band on accept, iterate while BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_hi    <= '0;
            md_lo    <= '0;
            md_op    <= '0;
            md_a     <= '0;
            md_f3    <= 3'd0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_bzero <= 1'b0;
            h_rs2    <= '0;
            h_pc     <= '0;
            h_instr  <= '0;
            h_mr     <= 1'b0;
            h_mw     <= 1'b0;
            h_mtr    <= 1'b0;
            h_jl     <= 1'b0;
            h_bt     <= 1'b0;
        end else if (state == S_IDLE && accept && is_mop) begin
            md_hi    <= '0;
            md_lo    <= a_mag;
            md_op    <= b_mag;
            md_a     <= A_in;
            md_f3    <= f3;
            md_neg_q <= a_neg ^ b_neg;
            md_neg_r <= a_neg;
            md_bzero <= (B_in == '0);
            h_rs2    <= rs2_data;
            h_pc     <= PC_in;
            h_instr  <= instr;
            h_mr     <= mem_read_en;
            h_mw     <= mem_write_en;
            h_mtr    <= mem_to_reg_en;
            h_jl     <= jumpl_en;
            h_bt     <= branch_en && br_cond;
        end else if (state == S_BUSY) begin
            if (!md_f3[2]) begin
                md_hi <= mul_sum[XLEN:1];
                md_lo <= {mul_sum[0], md_lo[XLEN-1:1]};
            end else begin
                md_hi <= div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
                md_lo <= {md_lo[XLEN-2:0], div_ge};
            end
        end
    end

    // EX/MEM output register: ALU accept, engine completion, or drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            alu_result   <= '0;
            rs2data_out  <= '0;
            mem_read_n   <= 1'b0;
            mem_write_n  <= 1'b0;
            mem_to_reg_n <= 1'b0;
            jumpl_n      <= 1'b0;
            branch_taken <= 1'b0;
            pc_out       <= '0;
            instr_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_mop) begin
            out_valid    <= 1'b1;
            alu_result   <= alu_val;
            rs2data_out  <= rs2_data;
            mem_read_n   <= mem_read_en;
            mem_write_n  <= mem_write_en;
            mem_to_reg_n <= mem_to_reg_en;
            jumpl_n      <= jumpl_en;
            branch_taken <= branch_en && br_cond;
            pc_out       <= PC_in;
            instr_out    <= instr;
        end else if (state == S_DONE) begin
            out_valid    <= 1'b1;
            alu_result   <= md_res;
            rs2data_out  <= h_rs2;
            mem_read_n   <= h_mr;
            mem_write_n  <= h_mw;
            mem_to_reg_n <= h_mtr;
            jumpl_n      <= h_jl;
            branch_taken <= h_bt;
            pc_out       <= h_pc;
            instr_out    <= h_instr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// tb/tb_ex_stage_muldiv.sv - directed self-checking bench for ex_stage_muldiv
module tb_ex_stage_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0, mem_to_reg_en = 1'b0;
    logic        jumpl_en = 1'b0, branch_en = 1'b0;
    logic [31:0] A_in = '0, B_in = '0, PC_n = '0, PC_in = '0, rs2_data = '0, instr = '0;
    logic [3:0]  alu_sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_result, rs2data_out, pc_out, instr_out;
    logic        mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_taken;

    int passed = 0;
    int total  = 0;

    ex_stage_muldiv dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_to_reg_en(mem_to_reg_en), .jumpl_en(jumpl_en), .branch_en(branch_en),
        .A_in(A_in), .B_in(B_in), .alu_sel(alu_sel), .PC_n(PC_n), .PC_in(PC_in),
        .rs2_data(rs2_data), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .rs2data_out(rs2data_out),
        .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
        .mem_to_reg_n(mem_to_reg_n), .jumpl_n(jumpl_n),
        .branch_taken(branch_taken), .pc_out(pc_out), .instr_out(instr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_instr(input logic [2:0] f);
        return {7'b0000001, 10'd0, f, 5'd1, 7'b0110011};
    endfunction

    function automatic logic [31:0] b_instr(input logic [2:0] f);
        return {17'd0, f, 5'd0, 7'b1100011};
    endfunction

    task automatic set_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ins);
        alu_sel = sel; A_in = a; B_in = b; instr = ins;
        jumpl_en = 1'b0; branch_en = 1'b0;
    endtask

    task automatic do_accept();
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Issues an M-op, counts edges to out_valid and checks the in_ready hold-off.
    task automatic run_m(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int n;
        logic busy_ok;
        set_op(4'd0, a, b, m_instr(f));
        do_accept();
        n = 0;
        busy_ok = 1'b1;
        while (!out_valid && n < 60) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, 33);
        check({tag, "_busy"}, busy_ok, 1);
        check(tag, alu_result, exp);
    endtask

    initial begin
        logic ok;

        // Reset state
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_result", alu_result, 0);
        check("rst_ctrl", {mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_taken}, 0);
        check("rst_pc_instr", {pc_out, instr_out}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ALU ops
        set_op(4'd0, 32'h7FFFFFFF, 32'h1, 32'h00000013);
        PC_in = 32'h00000040; rs2_data = 32'hDEADBEEF; mem_write_en = 1'b1;
        do_accept();
        check("add_valid", out_valid, 1);
        check("add", alu_result, 32'h80000000);
        check("add_side", {pc_out, rs2data_out}, {32'h00000040, 32'hDEADBEEF});
        check("add_mw", mem_write_n, 1);
        mem_write_en = 1'b0;
        set_op(4'd7, 32'hF0000000, 32'd4, 32'h00000013);  do_accept();
        check("sra", alu_result, 32'hFF000000);
        set_op(4'd1, 32'h0, 32'h1, 32'h00000013);         do_accept();
        check("sub_wrap", alu_result, 32'hFFFFFFFF);
        set_op(4'd5, 32'h1, 32'h21, 32'h00000013);        do_accept();
        check("sll_b40", alu_result, 32'h2);
        set_op(4'd8, 32'hFFFFFFFF, 32'h1, 32'h00000013);  do_accept();
        check("slt", alu_result, 1);
        set_op(4'd9, 32'hFFFFFFFF, 32'h1, 32'h00000013);  do_accept();
        check("sltu", alu_result, 0);
        set_op(4'd12, 32'h5, 32'h1234, 32'h00000013);     do_accept();
        check("passb", alu_result, 32'h1234);

        // Branches and jump link
        set_op(4'd0, 32'hFFFFFFFF, 32'h0, b_instr(3'b100));
        rs2_data = 32'h1; branch_en = 1'b1; do_accept();
        check("blt", branch_taken, 1);
        set_op(4'd0, 32'hFFFFFFFF, 32'h0, b_instr(3'b110));
        branch_en = 1'b1; do_accept();
        check("bltu", branch_taken, 0);
        set_op(4'd0, 32'h1, 32'h0, b_instr(3'b010));
        branch_en = 1'b1; do_accept();
        check("b_never", branch_taken, 0);
        set_op(4'd0, 32'h11, 32'h22, 32'h0000006F);
        jumpl_en = 1'b1; PC_n = 32'h00000104; do_accept();
        check("jal", alu_result, 32'h00000104);
        check("jal_flag", jumpl_n, 1);
        jumpl_en = 1'b0;

        // M-ops
        PC_in = 32'h00000200; rs2_data = 32'hCAFEF00D;
        run_m("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("mop_side", {pc_out, rs2data_out}, {32'h00000200, 32'hCAFEF00D});
        check("mop_instr", instr_out, m_instr(3'b010));
        run_m("mul",    3'b000, 32'h3,        32'hFFFFFFFB, 32'hFFFFFFF1);
        run_m("mulh",   3'b001, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF);
        run_m("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_m("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_m("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        run_m("divu_0", 3'b101, 32'h5,        32'h0,        32'hFFFFFFFF);
        run_m("remu_0", 3'b111, 32'h5,        32'h0,        32'h5);
        run_m("div_0",  3'b100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF);
        run_m("rem_0",  3'b110, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9);
        run_m("div_s",  3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
        run_m("rem_s",  3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
        run_m("divu",   3'b101, 32'd100,      32'd7,        32'd14);

        // Backpressure: output held, then simultaneous drain + accept
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_op(4'd0, 32'd2, 32'd3, 32'h00000013); do_accept();
        set_op(4'd0, 32'd10, 32'd20, 32'h00000013);
        in_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || alu_result !== 32'd5 || in_ready !== 1'b0) ok = 1'b0;
        end
        check("stall_hold", ok, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("drain_acc_valid", out_valid, 1);
        check("drain_acc_data", alu_result, 32'd30);
        @(posedge clk); #1;
        check("drained", out_valid, 0);

        // Flush at BUSY cycle 10
        set_op(4'd0, 32'd6, 32'd7, m_instr(3'b000)); do_accept();
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid !== 1'b0) ok = 1'b0;
        end
        check("flush_no_out", ok, 1);

        // Asynchronous reset while out_valid=1
        out_ready = 1'b0;
        PC_in = 32'h300;
        set_op(4'd0, 32'd1, 32'd1, 32'h00000013); do_accept();
        check("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", {alu_result, pc_out}, 0);
        check("async_rst_ready", in_ready, 1);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-BUSY
        set_op(4'd0, 32'd9, 32'd3, m_instr(3'b100)); do_accept();
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("busy_rst_ready", in_ready, 1);
        check("busy_rst_valid", out_valid, 0);
        #1 reset = 1'b1;
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid !== 1'b0) ok = 1'b0;
        end
        check("busy_rst_no_out", ok, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
